// File: rtl/ring_pkg.sv
// Shared definitions for the ring round-robin arbiter: FSM state encoding and
// the one-hot rotate helper used by the priority pointer.
package ring_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } ring_state_e;

  localparam int unsigned RING_MAX_N = 16;

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [RING_MAX_N-1:0] rotl_onehot(
    input logic [RING_MAX_N-1:0] v,
    input int unsigned           n
  );
    logic [31:0] w;
    logic [31:0] m;
    w = {16'b0, v};
    m = (32'd1 << n) - 32'd1;
    w = ((w << 1) | (w >> (n - 32'd1))) & m;
    return w[RING_MAX_N-1:0];
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// One-hot priority pointer ring: on en, loads base rotated left by one.
// Resets to bit 0.
module ring_ptr
  import ring_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] base,
  output logic [N-1:0] ptr
);

  logic [N-1:0]            ptr_d;
  logic [N-1:0]            ptr_q;
  logic [RING_MAX_N-1:0]   rot;

  always_comb begin
    rot   = rotl_onehot(RING_MAX_N'(base), N);
    ptr_d = en ? rot[N-1:0] : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot priority ring, owner hold and forced
// release after HOLD_MAX cycles. One IDLE turnaround cycle separates grants.
module ring_rr_arbiter
  import ring_pkg::*;
#(
  parameter int N        = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout,
  output logic [N-1:0]         ptr,
  output ring_state_e          state_dbg
);

  localparam int IW = $clog2(N);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  // Handshake: requester i holds req[i] high until served; the owner ends its
  // tenure with a done pulse (only honoured while grant_valid=1) or by
  // dropping req, otherwise the grant is pulled after HOLD_MAX cycles.
  ring_state_e   state_d, state_q;
  logic [N-1:0]  grant_d, grant_q;
  logic [IW-1:0] grant_id_d, grant_id_q;
  logic          grant_valid_d, grant_valid_q;
  logic          timeout_d, timeout_q;
  logic [7:0]    hold_cnt_d, hold_cnt_q;

  logic [N-1:0]  above;
  logic [N-1:0]  pick;
  logic [N-1:0]  win;
  logic [IW-1:0] win_id;
  logic          owner_req;
  logic          expiry;
  logic          rel;
  logic          ptr_en;

  // Cyclic search: prefer requests at or above the pointer, else wrap to the
  // lowest request overall; isolate the lowest set bit of the chosen set.
  always_comb begin
    above  = req & ~(ptr - N'(1));
    pick   = (above != '0) ? above : req;
    win    = pick & (~pick + N'(1));
    win_id = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) win_id = IW'(i);
    end
  end

  always_comb begin
    owner_req     = (req & grant_q) != '0;
    expiry        = hold_cnt_q == HOLD_LAST;
    rel           = done || !owner_req || expiry;
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    ptr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          state_d       = ST_OWNED;
          grant_d       = win;
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      ST_OWNED: begin
        if (rel) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          ptr_en        = 1'b1;
          // Only a pure expiry counts as forced; done or a dropped request wins.
          timeout_d     = expiry && !done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  ring_ptr #(.N(N)) u_ring_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ptr_en),
    .base  (grant_q),
    .ptr   (ptr)
  );

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter: directed scenarios plus random traffic
// checked against an integer-index reference model.
module tb_ring_rr_arbiter;
  import ring_pkg::*;

  localparam int N  = 8;
  localparam int HM = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          done;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [N-1:0]  ptr;
  logic          grant_valid;
  logic          timeout;
  logic [IW-1:0] grant_id;
  ring_state_e   state_dbg;

  always #5 clk = ~clk;

  ring_rr_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout),
    .ptr         (ptr),
    .state_dbg   (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // {ptr, timeout, grant_id, grant_valid, grant}
  logic [20:0] exp_q[$];

  bit m_owned;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_to;

  int fair_q[$];
  bit fair_en = 1'b0;
  logic prev_gv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owned = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_step(input logic [N-1:0] r, input logic d);
    bit found;
    int idx;
    m_to = 1'b0;
    if (!m_owned) begin
      if (r != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && r[idx]) begin
            found   = 1'b1;
            m_owner = idx;
          end
        end
        m_owned = 1'b1;
        m_held  = 1;
      end
    end else if (d || !r[m_owner] || m_held == HM) begin
      m_to    = (m_held == HM) && !d && r[m_owner];
      m_ptr   = (m_owner + 1) % N;
      m_owned = 1'b0;
    end else begin
      m_held++;
    end
  endtask

  task automatic drive_cycle(input logic [N-1:0] r, input logic d);
    logic [N-1:0]  eg;
    logic [N-1:0]  ep;
    logic [IW-1:0] eid;
    @(negedge clk);
    req  = r;
    done = d;
    model_step(r, d);
    eg  = m_owned ? (N'(1) << m_owner) : '0;
    eid = m_owned ? IW'(m_owner) : '0;
    ep  = N'(1) << m_ptr;
    exp_q.push_back({ep, m_to, eid, m_owned, eg});
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_grant_valid", 32'(grant_valid), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_ptr", 32'(ptr), 32'h1);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per clock edge once stimulus is running.
  initial begin
    logic [20:0] e;
    logic [20:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (fair_en && grant_valid && !prev_gv) fair_q.push_back(int'(grant_id));
      prev_gv = grant_valid;
      if (rst_n && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {ptr, timeout, grant_id, grant_valid, grant};
        n_vec++;
        if (act !== e) begin
          n_err++;
          $display("FAIL cycle t=%0t: got grant=%h gv=%b id=%0d to=%b ptr=%h, expected grant=%h gv=%b id=%0d to=%b ptr=%h",
                   $time, grant, grant_valid, grant_id, timeout, ptr,
                   e[7:0], e[8], e[11:9], e[12], e[20:13]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] cur;
    int cnt;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();

    // Single requester, done in its third grant cycle.
    reset_dut();
    repeat (3) drive_cycle(8'h01, 1'b0);
    drive_cycle(8'h01, 1'b1);
    repeat (2) drive_cycle(8'h00, 1'b0);

    // Everyone requesting, done asserted every cycle: strict rotation.
    reset_dut();
    repeat (20) drive_cycle(8'hFF, 1'b1);

    // Pointer at bit 6, wrap to bit 0, then bit 2.
    reset_dut();
    drive_cycle(8'h20, 1'b0);
    drive_cycle(8'h20, 1'b1);
    drive_cycle(8'h05, 1'b0);
    drive_cycle(8'h05, 1'b1);
    drive_cycle(8'h05, 1'b0);
    drive_cycle(8'h05, 1'b1);
    drive_cycle(8'h00, 1'b0);

    // Forced release after HOLD_MAX cycles.
    reset_dut();
    repeat (6) drive_cycle(8'h10, 1'b0);
    repeat (2) drive_cycle(8'h00, 1'b0);

    // done coinciding with expiry is a normal release.
    reset_dut();
    repeat (4) drive_cycle(8'h10, 1'b0);
    drive_cycle(8'h10, 1'b1);
    repeat (2) drive_cycle(8'h00, 1'b0);

    // Reset in the middle of a grant, then re-arbitrate from bit 0.
    reset_dut();
    repeat (3) drive_cycle(8'h08, 1'b0);
    reset_dut();
    repeat (4) drive_cycle(8'hFF, 1'b0);

    // Fairness window with random done.
    reset_dut();
    fair_q.delete();
    fair_en = 1'b1;
    repeat (60) drive_cycle(8'hFF, 1'($urandom_range(0, 2) == 0));
    @(posedge clk);
    #2;
    fair_en = 1'b0;
    if (fair_q.size() < N) begin
      n_vec++;
      n_err++;
      $display("FAIL fair_count: got %0d grants expected at least %0d", fair_q.size(), N);
    end else begin
      for (int id = 0; id < N; id++) begin
        cnt = 0;
        for (int j = 0; j < N; j++) if (fair_q[j] == id) cnt++;
        check($sformatf("fair_id%0d", id), 32'(cnt), 32'd1);
      end
    end

    // Random traffic.
    reset_dut();
    cur = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) cur = N'($urandom_range(0, 255));
      drive_cycle(cur, 1'($urandom_range(0, 3) == 0));
    end
    drive_cycle(8'h00, 1'b0);
    @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
